// File: rtl/sram_fi_pkg.sv
// Shared definitions for the fault-injectable SRAM model: fault type codes,
// fault entry field widths and the default fault table depth.
package sram_fi_pkg;

  localparam int FI_TYPE_WIDTH = 2;

  localparam logic [FI_TYPE_WIDTH-1:0] FI_SA0 = 2'b00;
  localparam logic [FI_TYPE_WIDTH-1:0] FI_SA1 = 2'b01;
  localparam logic [FI_TYPE_WIDTH-1:0] FI_TF  = 2'b10;
  localparam logic [FI_TYPE_WIDTH-1:0] FI_CF  = 2'b11;

  localparam int FI_DEFAULT_NUM_FAULTS = 4;

endpackage

// File: rtl/sram_fi_table.sv
// Runtime-programmable fault table: loads the lowest free entry on a
// fi_valid/fi_ready handshake, clears all entries on fi_clear.
module sram_fi_table
  import sram_fi_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int BIT_WIDTH  = 3,
  parameter int NUM_FAULTS = FI_DEFAULT_NUM_FAULTS,
  parameter int CNT_WIDTH  = $clog2(NUM_FAULTS) + 1
) (
  input  logic                                       b_clk,
  input  logic                                       b_rst_n,
  input  logic                                       fi_valid,
  input  logic [ADDR_WIDTH-1:0]                      fi_addr,
  input  logic [BIT_WIDTH-1:0]                       fi_bit,
  input  logic [FI_TYPE_WIDTH-1:0]                   fi_type,
  input  logic                                       fi_clear,
  output logic                                       fi_ready,
  output logic [CNT_WIDTH-1:0]                       fi_count,
  output logic [NUM_FAULTS-1:0]                      ent_valid,
  output logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0]      ent_addr,
  output logic [NUM_FAULTS-1:0][BIT_WIDTH-1:0]       ent_bit,
  output logic [NUM_FAULTS-1:0][FI_TYPE_WIDTH-1:0]   ent_type
);

  logic [NUM_FAULTS-1:0] load_sel;
  logic                  free_found;
  logic [CNT_WIDTH-1:0]  valid_count;

  // One-hot select of the lowest-index free slot
  always_comb begin
    load_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (!ent_valid[i] && !free_found) begin
        load_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (ent_valid[i]) valid_count = valid_count + CNT_WIDTH'(1);
    end
  end

  assign fi_ready = ~&ent_valid;
  assign fi_count = valid_count;

  // Clear wins over a simultaneous load
  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n) begin
      ent_valid <= '0;
      ent_addr  <= '0;
      ent_bit   <= '0;
      ent_type  <= '0;
    end else if (fi_clear) begin
      ent_valid <= '0;
    end else if (fi_valid && fi_ready) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (load_sel[i]) begin
          ent_valid[i] <= 1'b1;
          ent_addr[i]  <= fi_addr;
          ent_bit[i]   <= fi_bit;
          ent_type[i]  <= fi_type;
        end
      end
    end
  end

endmodule

// File: rtl/sram_8kx8_fi.sv
// Fault-injectable single-port SRAM responder: behavioural array plus
// stuck-at (read path), transition (write path) and coupling fault injection.
module sram_8kx8_fi
  import sram_fi_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int WE_WIDTH   = 1,
  parameter int NUM_FAULTS = FI_DEFAULT_NUM_FAULTS,
  parameter int BIT_WIDTH  = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH  = $clog2(NUM_FAULTS) + 1
) (
  input  logic                     b_clk,
  input  logic                     b_rst_n,
  input  logic                     cen,
  input  logic [WE_WIDTH-1:0]      wen,
  input  logic                     oen,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic [DATA_WIDTH-1:0]    q,
  input  logic                     fi_valid,
  output logic                     fi_ready,
  input  logic [ADDR_WIDTH-1:0]    fi_addr,
  input  logic [BIT_WIDTH-1:0]     fi_bit,
  input  logic [FI_TYPE_WIDTH-1:0] fi_type,
  input  logic                     fi_clear,
  output logic [CNT_WIDTH-1:0]     fi_count
);

  logic [NUM_FAULTS-1:0]                    ent_valid;
  logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0]    ent_addr;
  logic [NUM_FAULTS-1:0][BIT_WIDTH-1:0]     ent_bit;
  logic [NUM_FAULTS-1:0][FI_TYPE_WIDTH-1:0] ent_type;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_reg;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] cf_mask;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic                  do_read;
  logic                  do_write;

  sram_fi_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BIT_WIDTH  (BIT_WIDTH),
    .NUM_FAULTS (NUM_FAULTS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_table (
    .b_clk     (b_clk),
    .b_rst_n   (b_rst_n),
    .fi_valid  (fi_valid),
    .fi_addr   (fi_addr),
    .fi_bit    (fi_bit),
    .fi_type   (fi_type),
    .fi_clear  (fi_clear),
    .fi_ready  (fi_ready),
    .fi_count  (fi_count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_bit   (ent_bit),
    .ent_type  (ent_type)
  );

  assign do_read     = !cen && wen[0];
  assign do_write    = !cen && !wen[0];
  assign victim_addr = addr + ADDR_WIDTH'(1);

  // Stuck-at faults in index order so the highest matching entry wins
  always_comb begin
    rd_word = mem[addr];
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (ent_valid[i] && ent_addr[i] == addr) begin
        if (ent_type[i] == FI_SA0)      rd_word[ent_bit[i]] = 1'b0;
        else if (ent_type[i] == FI_SA1) rd_word[ent_bit[i]] = 1'b1;
      end
    end
  end

  // Transition faults block 0->1 on the stored bit; coupling hits on the
  // wrapped neighbour accumulate as an XOR mask
  always_comb begin
    old_word = mem[addr];
    wr_word  = data;
    cf_mask  = '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (ent_valid[i] && ent_addr[i] == addr) begin
        if (ent_type[i] == FI_TF) begin
          if (!old_word[ent_bit[i]] && data[ent_bit[i]]) wr_word[ent_bit[i]] = 1'b0;
        end else if (ent_type[i] == FI_CF) begin
          cf_mask[ent_bit[i]] = ~cf_mask[ent_bit[i]];
        end
      end
    end
  end

  always_ff @(posedge b_clk) begin
    if (do_write) begin
      mem[addr] <= wr_word;
      if (|cf_mask) mem[victim_addr] <= mem[victim_addr] ^ cf_mask;
    end
  end

  always_ff @(posedge b_clk or negedge b_rst_n) begin
    if (!b_rst_n)     q_reg <= '0;
    else if (do_read) q_reg <= rd_word;
  end

  assign q = oen ? '0 : q_reg;

endmodule

// File: tb/tb_sram_8kx8_fi.sv
// Directed self-checking bench for sram_8kx8_fi: read expectations go through
// a scoreboard queue and are compared one edge after the read is sampled.
module tb_sram_8kx8_fi;

  localparam logic [1:0] T_SA0 = 2'b00;
  localparam logic [1:0] T_SA1 = 2'b01;
  localparam logic [1:0] T_TF  = 2'b10;
  localparam logic [1:0] T_CF  = 2'b11;

  logic        b_clk = 1'b0;
  logic        b_rst_n;
  logic        cen;
  logic [0:0]  wen;
  logic        oen;
  logic [12:0] addr;
  logic [7:0]  data;
  logic [7:0]  q;
  logic        fi_valid;
  logic        fi_ready;
  logic [12:0] fi_addr;
  logic [2:0]  fi_bit;
  logic [1:0]  fi_type;
  logic        fi_clear;
  logic [2:0]  fi_count;

  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  sram_8kx8_fi dut (
    .b_clk    (b_clk),
    .b_rst_n  (b_rst_n),
    .cen      (cen),
    .wen      (wen),
    .oen      (oen),
    .addr     (addr),
    .data     (data),
    .q        (q),
    .fi_valid (fi_valid),
    .fi_ready (fi_ready),
    .fi_addr  (fi_addr),
    .fi_bit   (fi_bit),
    .fi_type  (fi_type),
    .fi_clear (fi_clear),
    .fi_count (fi_count)
  );

  always #5 b_clk = ~b_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [12:0] a, input logic [7:0] d,
                               input logic fv, input logic [12:0] fa, input logic [2:0] fb,
                               input logic [1:0] ft, input logic fc);
    @(negedge b_clk);
    cen      = c;
    wen      = w;
    addr     = a;
    data     = d;
    fi_valid = fv;
    fi_addr  = fa;
    fi_bit   = fb;
    fi_type  = ft;
    fi_clear = fc;
    @(posedge b_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expected;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      expected = exp_q.pop_front();
      check(tag, 16'(q), 16'(expected));
    end
  endtask

  task automatic doWrite(input logic [12:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, a, d, 1'b0, 13'h0, 3'h0, 2'b00, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [12:0] a, input logic [7:0] expected);
    exp_q.push_back(expected);
    applyStimulus(1'b0, 1'b1, a, 8'h00, 1'b0, 13'h0, 3'h0, 2'b00, 1'b0);
    checkOutput(tag);
  endtask

  task automatic doLoad(input logic [12:0] fa, input logic [2:0] fb, input logic [1:0] ft);
    applyStimulus(1'b1, 1'b1, 13'h0, 8'h00, 1'b1, fa, fb, ft, 1'b0);
  endtask

  task automatic doClear(input logic with_load);
    applyStimulus(1'b1, 1'b1, 13'h0, 8'h00, with_load, 13'h0042, 3'h1, T_SA1, 1'b1);
  endtask

  task automatic doIdle();
    applyStimulus(1'b1, 1'b1, 13'h0, 8'h00, 1'b0, 13'h0, 3'h0, 2'b00, 1'b0);
  endtask

  initial begin
    b_rst_n  = 1'b0;
    cen      = 1'b1;
    wen      = 1'b1;
    oen      = 1'b0;
    addr     = '0;
    data     = '0;
    fi_valid = 1'b0;
    fi_addr  = '0;
    fi_bit   = '0;
    fi_type  = '0;
    fi_clear = 1'b0;
    repeat (2) @(posedge b_clk);
    #1;
    check("reset_q", 16'(q), 16'h00);
    check("reset_count", 16'(fi_count), 16'd0);
    check("reset_ready", 16'(fi_ready), 16'd1);
    @(negedge b_clk);
    b_rst_n = 1'b1;

    $display("[TB] fault-free read/write and oen");
    doWrite(13'h0000, 8'hA5);
    doWrite(13'h1FFF, 8'h5A);
    doRead("read_0000", 13'h0000, 8'hA5);
    doRead("read_1fff", 13'h1FFF, 8'h5A);
    doIdle();
    oen = 1'b1;
    #1;
    check("oen_high_q", 16'(q), 16'h00);
    oen = 1'b0;
    #1;
    check("oen_low_q_hold", 16'(q), 16'h5A);

    $display("[TB] stuck-at-1 then clear");
    doLoad(13'h0010, 3'd3, T_SA1);
    check("sa1_count", 16'(fi_count), 16'd1);
    doWrite(13'h0010, 8'h00);
    doRead("sa1_read", 13'h0010, 8'h08);
    doClear(1'b0);
    check("clear_count", 16'(fi_count), 16'd0);
    doRead("sa1_cleared_read", 13'h0010, 8'h00);

    $display("[TB] transition fault");
    doLoad(13'h0020, 3'd0, T_TF);
    doWrite(13'h0020, 8'h00);
    doWrite(13'h0020, 8'hFF);
    doRead("tf_read", 13'h0020, 8'hFE);
    doWrite(13'h0021, 8'h01);
    doRead("tf_neighbour_read", 13'h0021, 8'h01);
    doClear(1'b0);

    $display("[TB] coupling fault with wrap-around victim");
    doLoad(13'h1FFF, 3'd7, T_CF);
    doWrite(13'h0000, 8'h00);
    doWrite(13'h1FFF, 8'h33);
    doRead("cf_victim_read", 13'h0000, 8'h80);
    doRead("cf_aggressor_read", 13'h1FFF, 8'h33);
    doLoad(13'h1FFF, 3'd7, T_CF);
    check("cf_dup_count", 16'(fi_count), 16'd2);
    doWrite(13'h1FFF, 8'h44);
    doRead("cf_xor_accum_read", 13'h0000, 8'h80);
    doClear(1'b0);

    $display("[TB] full table, dropped load, clear priority");
    doLoad(13'h0100, 3'd0, T_SA0);
    doLoad(13'h0100, 3'd1, T_SA0);
    doLoad(13'h0100, 3'd2, T_SA0);
    check("three_ready", 16'(fi_ready), 16'd1);
    doLoad(13'h0100, 3'd3, T_SA0);
    check("full_ready", 16'(fi_ready), 16'd0);
    check("full_count", 16'(fi_count), 16'd4);
    doLoad(13'h0100, 3'd7, T_SA1);
    check("fifth_dropped_count", 16'(fi_count), 16'd4);
    doWrite(13'h0100, 8'hFF);
    doRead("sa0_multi_read", 13'h0100, 8'hF0);
    doClear(1'b1);
    check("clear_vs_load_count", 16'(fi_count), 16'd0);
    check("clear_vs_load_ready", 16'(fi_ready), 16'd1);
    doWrite(13'h0042, 8'h00);
    doRead("clear_vs_load_no_fault", 13'h0042, 8'h00);

    $display("[TB] highest index wins a stuck-at conflict");
    doLoad(13'h0200, 3'd2, T_SA0);
    doLoad(13'h0200, 3'd2, T_SA1);
    doWrite(13'h0200, 8'h00);
    doRead("sa_conflict_read", 13'h0200, 8'h04);

    $display("[TB] reset during read burst");
    doWrite(13'h0300, 8'hC3);
    doWrite(13'h0301, 8'h3C);
    doRead("pre_reset_read", 13'h0300, 8'hC3);
    b_rst_n = 1'b0;
    #1;
    check("reset_async_q", 16'(q), 16'h00);
    check("reset_async_count", 16'(fi_count), 16'd0);
    check("reset_async_ready", 16'(fi_ready), 16'd1);
    cen = 1'b1;
    repeat (2) @(posedge b_clk);
    @(negedge b_clk);
    b_rst_n = 1'b1;
    doRead("post_reset_read_300", 13'h0300, 8'hC3);
    doRead("post_reset_read_301", 13'h0301, 8'h3C);
    doRead("post_reset_read_200", 13'h0200, 8'h00);
    doIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_8kx8_fi.md
# sram_8kx8_fi

Fault-injectable 8K x 8 single-port SRAM responder model. It is the memory-side counterpart of the BIST engine: it sits behind the test/functional mux and accepts `cen`/`wen`/`oen`/`addr`/`data` exactly as the BIST or functional path drives them. Read data returns on `q`. A small runtime-programmable fault table injects stuck-at, transition and coupling faults, so the BIST pass/fail logic can be checked in simulation and on FPGA.

## Interface
Parameters:
- `ADDR_WIDTH`, 13 — address bits; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8 — word width.
- `WE_WIDTH`, 1 — write-enable bits; one bit per whole word, so only 1 is legal.
- `NUM_FAULTS`, 4 — fault table entries.

Ports (clock and reset first):
- `b_clk` in 1 — clock. All state changes on the rising edge.
- `b_rst_n` in 1 — reset, asynchronous, active-low.
- `cen` in 1 — chip enable, active-low.
- `wen` in WE_WIDTH — write enable, active-low; 0 = write, 1 = read.
- `oen` in 1 — output enable, active-low.
- `addr` in ADDR_WIDTH — word address.
- `data` in DATA_WIDTH — write data.
- `q` out DATA_WIDTH — read data.
- `fi_valid` in 1 — fault-entry load request.
- `fi_ready` out 1 — at least one table entry is free.
- `fi_addr` in ADDR_WIDTH — faulty cell address (aggressor address for CF).
- `fi_bit` in log2(DATA_WIDTH) — faulty bit index.
- `fi_type` in 2 — 00 SA0, 01 SA1, 10 TF (0→1 write fails), 11 CF.
- `fi_clear` in 1 — single-cycle pulse that invalidates all entries.
- `fi_count` out log2(NUM_FAULTS)+1 — number of valid entries.

## Operation
- Array: `reg` array, not reset. Contents survive `b_rst_n`.
- Read: at the clock edge with `cen`=0 and `wen`=1, `q_reg` ← mem[addr] with the read-path faults applied.
- Read-path faults: for each valid SA0/SA1 entry with entry address == addr, force that bit to 0 or 1. Entries are applied in index order; the highest index wins a conflict.
- `q` = `oen` ? 0 : `q_reg`. This is combinational on `oen`.
- Write: at the clock edge with `cen`=0 and `wen`=0, mem[addr] ← the write-path-modified `data`.
  - TF entry matching addr: if the stored bit is 0 and the new bit is 1, the stored bit stays 0.
  - SA entries do not alter stored data; they act on reads only.
- Coupling (CF): a write to `fi_addr` inverts bit `fi_bit` of mem[fi_addr+1], where the address wraps from 2^ADDR_WIDTH−1 to 0.
  - This happens in the same edge as the aggressor write.
  - It uses the victim's pre-edge content.
  - Multiple CF hits on the same victim bit are XOR-accumulated.
- `cen`=1: no array access; `q_reg` holds.
- Fault table: the handshake is `fi_valid` & `fi_ready`. It loads the lowest-index free entry.
  - `fi_ready` = any entry invalid.
  - `fi_valid` while `fi_ready`=0 is dropped; no error flag.
  - `fi_clear` has priority over a simultaneous load; the load is discarded.
  - A table change takes effect on accesses from the next edge onward.
- Duplicate entries (same addr/bit/type) are legal and occupy separate slots.

## Timing
- Read latency: 1 cycle. `q` is valid after the edge that sampled the read and stays stable until the next read edge.
- Write: completes in one edge. A read of the same address on the next cycle returns the new data.
- Reset values: `q_reg`=0, so `q`=0; all entries invalid; `fi_count`=0; `fi_ready`=1.
- Reset asserted mid-write: the write is not guaranteed. Asserted mid-read: `q`=0 immediately.
- `fi_count` and `fi_ready` update on the edge after a load or clear.
- Back-to-back reads and writes are allowed every cycle with no bubbles.

## Structure
- Package `sram_fi_pkg`:
  - fault type localparams `FI_SA0`, `FI_SA1`, `FI_TF`, `FI_CF`;
  - entry field widths;
  - the default `NUM_FAULTS`.
- Sub-module `sram_fi_table` holds the fault entries, the load/clear handshake and `fi_count`. It exports per-entry valid/addr/bit/type vectors.
- Top level contains the array, the read/write fault masking loops and the `q` register.

## Test plan
- No faults loaded: write 0xA5 to 0x0000 and 0x5A to 0x1FFF, then read both → `q`=0xA5, then 0x5A, each one cycle after its read edge; `oen`=1 → `q`=0x00.
- Load SA1 at addr 0x0010, bit 3; write 0x00 to 0x0010, then read → `q`=0x08. Then `fi_clear` and read again → `q`=0x00.
- Load TF at 0x0020, bit 0; write 0x00, then 0xFF, then read → `q`=0xFE. Write 0x01 to 0x0021 and read → `q`=0x01.
- Load CF at 0x1FFF, bit 7; write 0x00 to 0x0000, write any value to 0x1FFF, read 0x0000 → `q`=0x80 (wrap-around victim).
- Load 4 entries → `fi_ready`=0, `fi_count`=4. A fifth `fi_valid` is ignored. `fi_clear` together with `fi_valid` → `fi_count`=0.
- Assert `b_rst_n` low during a read burst → `q`=0 immediately and `fi_count`=0. After release, previously written data reads back intact.
